adc_capture_ctrl: RTL and testbench

//  Sequencer for the ADC sample FIFO. Arms the FIFO and streams ADC samples into it as a rolling
//  pre-trigger buffer. Detects a rising-edge level trigger, captures a programmed post-trigger

---
 rtl/adc_capture_pkg.sv | 15 +
 rtl/adc_trig_detect.sv | 50 +++++
 rtl/adc_capture_ctrl.sv | 152 +++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture sequencer.
// The FSM encoding is visible on the top-level state port, so values are fixed.
package adc_capture_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PRE     = 3'd1,
      POST    = 3'd2,
      READOUT = 3'd3
   } state_t;

   localparam logic TRIG_MODE_FIRST = 1'b0;
   localparam logic TRIG_MODE_LEVEL = 1'b1;

endpackage

// File: rtl/adc_trig_detect.sv
// Registers the incoming ADC sample and flags the trigger sample.
// The previous-sample qualifier is cleared while idle, so a level trigger needs a crossing seen after arming.
module adc_trig_detect
   import adc_capture_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clear,
   input  logic                  i_trigEn,
   input  logic [DATA_WIDTH-1:0] i_trigLevel,
   input  logic [DATA_WIDTH-1:0] i_adcData,
   input  logic                  i_adcValid,
   output logic [DATA_WIDTH-1:0] o_sData,
   output logic                  o_sValid,
   output logic                  o_trig
);

   logic [DATA_WIDTH-1:0] r_sData;
   logic                  r_sValid;
   logic [DATA_WIDTH-1:0] r_prevData;
   logic                  r_prevValid;
   logic                  w_cross;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sData     <= '0;
         r_sValid    <= 1'b0;
         r_prevData  <= '0;
         r_prevValid <= 1'b0;
      end else begin
         r_sData  <= i_adcData;
         r_sValid <= i_adcValid;
         if (i_clear) begin
            r_prevValid <= 1'b0;
         end else if (r_sValid) begin
            r_prevData  <= r_sData;
            r_prevValid <= 1'b1;
         end
      end
   end

   // Rising crossing: last valid sample strictly below the threshold, this one at or above it.
   assign w_cross  = r_prevValid && (r_prevData < i_trigLevel) && (r_sData >= i_trigLevel);
   assign o_trig   = r_sValid && ((i_trigEn == TRIG_MODE_FIRST) || w_cross);
   assign o_sData  = r_sData;
   assign o_sValid = r_sValid;

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: rolling pre-trigger buffer, post-trigger count, host readout.
// FIFO strobes are combinational from the registered sample stage; status outputs are registered.
module adc_capture_ctrl
   import adc_capture_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 15,
   parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm,
   input  logic                  abort,
   input  logic                  trig_en,
   input  logic [DATA_WIDTH-1:0] trig_level,
   input  logic [CNT_WIDTH-1:0]  post_len,
   input  logic [DATA_WIDTH-1:0] adc_data,
   input  logic                  adc_valid,
   output logic                  fifo_start,
   output logic                  fifo_wr,
   output logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd,
   input  logic [DATA_WIDTH-1:0] fifo_q,
   input  logic                  fifo_empty,
   input  logic                  fifo_full,
   input  logic                  host_rd,
   output logic [DATA_WIDTH-1:0] host_data,
   output logic                  host_valid,
   output logic [2:0]            state,
   output logic                  done,
   output logic                  overflow
);

   state_t                r_state;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic                  r_done;
   logic                  r_overflow;
   logic                  r_hostValid;

   logic [DATA_WIDTH-1:0] w_sData;
   logic                  w_sValid;
   logic                  w_trig;
   logic                  w_fifoWr;
   logic                  w_fifoRd;
   logic                  w_hostRd;

   adc_trig_detect #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_trigDetect (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_clear     (r_state == IDLE),
      .i_trigEn    (trig_en),
      .i_trigLevel (trig_level),
      .i_adcData   (adc_data),
      .i_adcValid  (adc_valid),
      .o_sData     (w_sData),
      .o_sValid    (w_sValid),
      .o_trig      (w_trig)
   );

   // In PRE a write into a full FIFO is paired with a discard read so the window keeps rolling.
   always_comb begin
      w_fifoWr = 1'b0;
      w_fifoRd = 1'b0;
      w_hostRd = 1'b0;
      if (!rst && !abort) begin
         case (r_state)
            PRE: begin
               w_fifoWr = w_sValid;
               w_fifoRd = w_sValid && fifo_full;
            end
            POST: begin
               w_fifoWr = w_sValid && !fifo_full;
            end
            READOUT: begin
               w_hostRd = host_rd && !fifo_empty;
               w_fifoRd = w_hostRd;
            end
            default: begin
               w_fifoWr = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_overflow  <= 1'b0;
         r_hostValid <= 1'b0;
      end else if (abort) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_hostValid <= 1'b0;
      end else begin
         r_done      <= 1'b0;
         r_hostValid <= w_hostRd;
         case (r_state)
            IDLE: begin
               if (arm) begin
                  r_state    <= PRE;
                  r_overflow <= 1'b0;
               end
            end
            PRE: begin
               if (w_trig) begin
                  r_cnt   <= post_len;
                  r_state <= (post_len == '0) ? READOUT : POST;
               end
            end
            POST: begin
               if (w_sValid) begin
                  if (fifo_full) begin
                     r_overflow <= 1'b1;
                     r_state    <= READOUT;
                  end else begin
                     r_cnt <= r_cnt - CNT_WIDTH'(1);
                     if (r_cnt == CNT_WIDTH'(1)) begin
                        r_state <= READOUT;
                     end
                  end
               end
            end
            READOUT: begin
               // Leave only once the last word read has been presented to the host.
               if (fifo_empty && !r_hostValid) begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign fifo_start = (r_state != IDLE);
   assign fifo_wr    = w_fifoWr;
   assign fifo_data  = w_sData;
   assign fifo_rd    = w_fifoRd;
   assign host_data  = fifo_q;
   assign host_valid = r_hostValid;
   assign state      = r_state;
   assign done       = r_done;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized scoreboard bench for adc_capture_ctrl driving a behavioural 15-word FIFO.
// The reference model derives FIFO contents from the sample list, trigger rule and post length.
module tb_adc_capture_ctrl;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int CW    = AW + 1;
   localparam int DEPTH = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic          trig_en = 1'b0;
   logic [DW-1:0] trig_level = '0;
   logic [CW-1:0] post_len = '0;
   logic [DW-1:0] adc_data = '0;
   logic          adc_valid = 1'b0;
   logic          fifo_start;
   logic          fifo_wr;
   logic [DW-1:0] fifo_data;
   logic          fifo_rd;
   logic [DW-1:0] fifo_q = '0;
   logic          fifo_empty;
   logic          fifo_full;
   logic          host_rd = 1'b0;
   logic [DW-1:0] host_data;
   logic          host_valid;
   logic [2:0]    state;
   logic          done;
   logic          overflow;

   int            checks = 0;
   int            errors = 0;
   int            stim[$];
   logic [DW-1:0] expQ[$];
   bit            expOverflow;
   logic [DW-1:0] fifoMem[$];
   int            fifoCount = 0;
   int            fifoAbuse = 0;
   int            doneCount = 0;
   int            strayValid = 0;

   adc_capture_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .arm        (arm),
      .abort      (abort),
      .trig_en    (trig_en),
      .trig_level (trig_level),
      .post_len   (post_len),
      .adc_data   (adc_data),
      .adc_valid  (adc_valid),
      .fifo_start (fifo_start),
      .fifo_wr    (fifo_wr),
      .fifo_data  (fifo_data),
      .fifo_rd    (fifo_rd),
      .fifo_q     (fifo_q),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .host_rd    (host_rd),
      .host_data  (host_data),
      .host_valid (host_valid),
      .state      (state),
      .done       (done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Behavioural FIFO: 15 usable words, full flag at 15, read data one cycle after fifo_rd.
   always @(posedge clk) begin
      if (!fifo_start) begin
         fifoMem.delete();
      end else begin
         if (fifo_rd) begin
            if (fifoMem.size() > 0) fifo_q <= fifoMem.pop_front();
            else fifoAbuse <= fifoAbuse + 1;
         end
         if (fifo_wr) begin
            if (fifoMem.size() >= DEPTH) fifoAbuse <= fifoAbuse + 1;
            else fifoMem.push_back(fifo_data);
         end
      end
      fifoCount <= fifoMem.size();
   end

   assign fifo_empty = (fifoCount == 0);
   assign fifo_full  = (fifoCount == DEPTH);

   // Monitor: every word handed to the host is compared against the scoreboard queue.
   always @(negedge clk) begin
      if (done) doneCount <= doneCount + 1;
      if (host_valid) begin
         if (state != 3'd3) strayValid <= strayValid + 1;
         checks = checks + 1;
         if (expQ.size() == 0) begin
            errors = errors + 1;
            $display("[TB] FAIL hostWordUnexpected actual %0d required none", host_data);
         end else if (host_data !== expQ[0]) begin
            errors = errors + 1;
            $display("[TB] FAIL hostWord actual %0d required %0d", host_data, expQ[0]);
            void'(expQ.pop_front());
         end else begin
            void'(expQ.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s actual %0d required %0d", name, actual, expected);
      end
   endtask

   function automatic int findTrig(input bit te, input int lvl);
      for (int i = 0; i < stim.size(); i++) begin
         if (!te) return 0;
         if (i > 0 && stim[i-1] < lvl && stim[i] >= lvl) return i;
      end
      return -1;
   endfunction

   // Reference: keep the newest 15 samples up to the trigger, then append post samples until full.
   task automatic buildModel(input bit te, input int lvl, input int pl);
      int t;
      int win[$];
      t = findTrig(te, lvl);
      expOverflow = 1'b0;
      for (int i = 0; i <= t; i++) begin
         win.push_back(stim[i]);
         if (win.size() > DEPTH) void'(win.pop_front());
      end
      for (int k = 1; k <= pl; k++) begin
         if (win.size() == DEPTH) begin
            expOverflow = 1'b1;
            break;
         end
         win.push_back(stim[t+k]);
      end
      foreach (win[i]) expQ.push_back(win[i][DW-1:0]);
   endtask

   task automatic pulseArm();
      arm = 1'b1;
      adc_valid = 1'b0;
      tick();
      arm = 1'b0;
   endtask

   task automatic applyStimulus(input bit contValid, input bit hostNoise);
      int idx = 0;
      int guard = 0;
      while (state != 3'd3 && guard < 3000) begin
         if (idx < stim.size() && (contValid || $urandom_range(0, 3) != 0)) begin
            adc_data  = stim[idx][DW-1:0];
            adc_valid = 1'b1;
            idx++;
         end else begin
            adc_data  = DW'($urandom);
            adc_valid = 1'b0;
         end
         host_rd = hostNoise ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         guard++;
      end
      adc_valid = 1'b0;
      checkOutput("reachReadout", 32'(state), 32'd3);
   endtask

   task automatic drain();
      int guard = 0;
      int doneBase;
      doneBase = doneCount;
      while (doneCount == doneBase && guard < 2000) begin
         host_rd = ($urandom_range(0, 2) != 0);
         tick();
         guard++;
      end
      host_rd = 1'b0;
      tick();
      tick();
      checkOutput("donePulses", 32'(doneCount - doneBase), 32'd1);
      checkOutput("wordsLeft", 32'(expQ.size()), 32'd0);
      checkOutput("idleAfterDone", 32'(state), 32'd0);
      checkOutput("fifoStartIdle", 32'(fifo_start), 32'd0);
      checkOutput("overflowFlag", 32'(overflow), 32'(expOverflow));
      expQ.delete();
   endtask

   task automatic runCapture(input bit te, input int lvl, input int pl, input bit contValid, input bit hostNoise);
      int abuseBase;
      int strayBase;
      abuseBase  = fifoAbuse;
      strayBase  = strayValid;
      trig_en    = te;
      trig_level = lvl[DW-1:0];
      post_len   = pl[CW-1:0];
      buildModel(te, lvl, pl);
      pulseArm();
      checkOutput("armState", 32'(state), 32'd1);
      checkOutput("armClearsOverflow", 32'(overflow), 32'd0);
      checkOutput("armFifoStart", 32'(fifo_start), 32'd1);
      applyStimulus(contValid, hostNoise);
      drain();
      checkOutput("hostValidOutsideReadout", 32'(strayValid - strayBase), 32'd0);
      checkOutput("fifoMisuse", 32'(fifoAbuse - abuseBase), 32'd0);
   endtask

   task automatic genRandom(output bit te, output int lvl, output int pl);
      int t;
      do begin
         te  = 1'($urandom_range(0, 1));
         lvl = $urandom_range(40, 200);
         pl  = $urandom_range(0, 20);
         stim.delete();
         for (int i = 0; i < 80; i++) stim.push_back($urandom_range(0, 255));
         t = findTrig(te, lvl);
      end while (t < 0 || t + pl + 1 > 80);
   endtask

   initial begin
      bit te;
      int lvl;
      int pl;

      repeat (3) tick();
      rst = 1'b0;
      tick();
      checkOutput("rstState", 32'(state), 32'd0);
      checkOutput("rstFifoStart", 32'(fifo_start), 32'd0);
      checkOutput("rstFifoWr", 32'(fifo_wr), 32'd0);
      checkOutput("rstFifoRd", 32'(fifo_rd), 32'd0);
      checkOutput("rstHostValid", 32'(host_valid), 32'd0);
      checkOutput("rstDone", 32'(done), 32'd0);
      checkOutput("rstOverflow", 32'(overflow), 32'd0);

      // Immediate trigger, short post count.
      stim.delete();
      for (int i = 1; i <= 10; i++) stim.push_back(i);
      runCapture(1'b0, 0, 3, 1'b1, 1'b0);

      // Level trigger on a ramp.
      stim.delete();
      for (int i = 0; i <= 20; i++) stim.push_back(i * 10);
      runCapture(1'b1, 100, 2, 1'b0, 1'b0);

      // Long pre-trigger history rolls the window; host pokes during PRE.
      stim.delete();
      for (int i = 0; i < 40; i++) stim.push_back(i);
      stim.push_back(150);
      for (int i = 0; i < 5; i++) stim.push_back(160 + i);
      runCapture(1'b1, 100, 0, 1'b0, 1'b1);

      // Post count larger than the FIFO forces overflow.
      stim.delete();
      for (int i = 0; i < 40; i++) stim.push_back(1000 + i);
      runCapture(1'b0, 0, 20, 1'b1, 1'b0);

      // Overflow must clear on the next accepted arm.
      stim.delete();
      for (int i = 0; i < 10; i++) stim.push_back(300 + i);
      runCapture(1'b0, 0, 1, 1'b1, 1'b0);

      // Abort in POST, with an ignored arm first.
      trig_en  = 1'b0;
      post_len = CW'(10);
      pulseArm();
      for (int i = 0; i < 5; i++) begin
         adc_data  = DW'(900 + i);
         adc_valid = 1'b1;
         tick();
      end
      adc_valid = 1'b0;
      checkOutput("postBeforeAbort", 32'(state), 32'd2);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      checkOutput("armIgnoredInPost", 32'(state), 32'd2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abortState", 32'(state), 32'd0);
      checkOutput("abortFifoStart", 32'(fifo_start), 32'd0);
      checkOutput("abortFifoWr", 32'(fifo_wr), 32'd0);
      checkOutput("abortHostValid", 32'(host_valid), 32'd0);
      tick();
      stim.delete();
      for (int i = 0; i < 10; i++) stim.push_back(2000 + i);
      runCapture(1'b0, 0, 4, 1'b0, 1'b0);

      // Synchronous reset in the middle of readout.
      stim.delete();
      for (int i = 0; i < 12; i++) stim.push_back(4000 + i);
      trig_en  = 1'b0;
      post_len = CW'(6);
      buildModel(1'b0, 0, 6);
      pulseArm();
      applyStimulus(1'b1, 1'b0);
      host_rd = 1'b1;
      repeat (3) tick();
      host_rd = 1'b0;
      repeat (2) tick();
      checkOutput("readsBeforeReset", 32'(expQ.size()), 32'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rstReadoutState", 32'(state), 32'd0);
      checkOutput("rstReadoutFifoStart", 32'(fifo_start), 32'd0);
      checkOutput("rstReadoutFifoRd", 32'(fifo_rd), 32'd0);
      checkOutput("rstReadoutHostValid", 32'(host_valid), 32'd0);
      checkOutput("rstReadoutDone", 32'(done), 32'd0);
      expQ.delete();
      tick();

      // Randomized captures.
      for (int n = 0; n < 8; n++) begin
         genRandom(te, lvl, pl);
         runCapture(te, lvl, pl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
